// File: rtl/kernel_bc_hls_dl_pkg.sv
// kernel_bc_hls_dl_pkg: shared state encoding and sizing helpers for the deadlock report controller
package kernel_bc_hls_dl_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_ORIGIN, ST_TRACE, ST_REPORT, ST_ABORT} dl_state_e;
    localparam int DEFAULT_TIMEOUT = 64;
    // A single process still needs a one-bit index.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/kernel_bc_hls_rr_arbiter.sv
// kernel_bc_hls_rr_arbiter: combinational round-robin pick of the first request at or above base
//   req_i   : per-process request flags
//   base_i  : search start index
//   grant_o : selected index (valid only with valid_o)
//   valid_o : any request present
module kernel_bc_hls_rr_arbiter #(
    parameter int PROC_NUM  = 4,
    parameter int PROC_ID_W = 2
) (
    input  logic [PROC_NUM-1:0]  req_i,
    input  logic [PROC_ID_W-1:0] base_i,
    output logic [PROC_ID_W-1:0] grant_o,
    output logic                 valid_o
);
    int k;
    // Walk offsets from far to near so the nearest request at or above base wins.
    always_comb begin
        grant_o = '0;
        valid_o = |req_i;
        k = 0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            k = (int'(base_i) + i) % PROC_NUM;
            if (req_i[k]) grant_o = PROC_ID_W'(k);
        end
    end
endmodule

// File: rtl/kernel_bc_hls_deadlock_report_ctrl.sv
// kernel_bc_hls_deadlock_report_ctrl: sequences origin pick, global freeze, token trace and deadlock report
//   clock/reset        : rising-edge clock, synchronous active-high reset
//   enable             : allows a new detection to start from IDLE
//   proc_dl_vec        : per-unit local deadlock flags
//   dl_detect_bcast    : global detect/freeze to every unit
//   origin_vec         : one-hot origin strobe
//   token_clear_vec    : one-hot token clear, combinational on token return
//   deadlock*          : confirmed report (flag, origin index, trace length)
//   report_ack         : host release of the report
module kernel_bc_hls_deadlock_report_ctrl
    import kernel_bc_hls_dl_pkg::*;
#(
    parameter int PROC_NUM  = 4,
    parameter int PROC_ID_W = id_width(PROC_NUM),
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int CNT_W     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PROC_NUM-1:0]  proc_dl_vec,
    output logic                 dl_detect_bcast,
    output logic [PROC_NUM-1:0]  origin_vec,
    output logic [PROC_NUM-1:0]  token_clear_vec,
    output logic                 deadlock,
    output logic [PROC_ID_W-1:0] deadlock_proc_id,
    output logic [CNT_W-1:0]     deadlock_trace_len,
    input  logic                 report_ack
);
    dl_state_e            state_q, state_d;
    logic [PROC_ID_W-1:0] rr_q, rr_d, sel_q, sel_d, id_q, id_d, grant, sel_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_d, len_q, len_d;
    logic                 grant_valid, ret;

    kernel_bc_hls_rr_arbiter #(.PROC_NUM(PROC_NUM), .PROC_ID_W(PROC_ID_W)) u_arb (
        .req_i  (proc_dl_vec),
        .base_i (rr_q),
        .grant_o(grant),
        .valid_o(grant_valid)
    );

    // Token has come back to the origin; only the origin's flag matters.
    assign ret     = (state_q == ST_TRACE) && proc_dl_vec[sel_q];
    assign sel_nxt = (sel_q == PROC_ID_W'(PROC_NUM - 1)) ? '0 : sel_q + 1'b1;

    assign dl_detect_bcast    = (state_q == ST_ORIGIN) || (state_q == ST_TRACE) || (state_q == ST_REPORT);
    assign origin_vec         = (state_q == ST_ORIGIN) ? PROC_NUM'(1) << sel_q : '0;
    assign token_clear_vec    = ret ? PROC_NUM'(1) << sel_q : '0;
    assign deadlock           = state_q == ST_REPORT;
    assign deadlock_proc_id   = deadlock ? id_q : '0;
    assign deadlock_trace_len = deadlock ? len_q : '0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: if (enable && grant_valid) begin
                sel_d   = grant;
                state_d = ST_ORIGIN;
            end
            ST_ORIGIN: begin
                cnt_d   = '0;
                state_d = ST_TRACE;
            end
            ST_TRACE: begin
                cnt_d = cnt_q + 1'b1;
                if (ret) begin
                    id_d    = sel_q;
                    len_d   = cnt_q + 1'b1;
                    state_d = ST_REPORT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ABORT;
                end
            end
            ST_REPORT: if (report_ack) begin
                rr_d    = sel_nxt;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                rr_d    = sel_nxt;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_kernel_bc_hls_deadlock_report_ctrl.sv
// tb_kernel_bc_hls_deadlock_report_ctrl: scoreboard bench for the deadlock report controller
module tb_kernel_bc_hls_deadlock_report_ctrl;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 8;
    localparam int CW = 8;

    logic          clock = 1'b0, reset = 1'b1, enable = 1'b0, report_ack = 1'b0;
    logic [N-1:0]  proc_dl_vec = '0;
    logic          dl_detect_bcast, deadlock;
    logic [N-1:0]  origin_vec, token_clear_vec;
    logic [IW-1:0] deadlock_proc_id;
    logic [CW-1:0] deadlock_trace_len;

    kernel_bc_hls_deadlock_report_ctrl #(.PROC_NUM(N), .PROC_ID_W(IW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .proc_dl_vec       (proc_dl_vec),
        .dl_detect_bcast   (dl_detect_bcast),
        .origin_vec        (origin_vec),
        .token_clear_vec   (token_clear_vec),
        .deadlock          (deadlock),
        .deadlock_proc_id  (deadlock_proc_id),
        .deadlock_trace_len(deadlock_trace_len),
        .report_ack        (report_ack)
    );

    always #5 clock = ~clock;

    int   n_tests = 0, n_fail = 0;
    int   org_q[$], id_q[$], len_q[$];
    logic dl_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: origin strobes and rising deadlock reports are matched to queued expectations.
    always @(negedge clock) begin
        if (origin_vec != '0) begin
            if (org_q.size() == 0) chk("origin_unexp", 32'(origin_vec), 0);
            else chk("origin", 32'(origin_vec), 32'(1) << org_q.pop_front());
            chk("org_tc_excl", 32'(token_clear_vec), 0);
        end
        if (deadlock && !dl_prev) begin
            if (id_q.size() == 0) chk("report_unexp", 32'(deadlock), 0);
            else begin
                chk("rep_id", 32'(deadlock_proc_id), id_q.pop_front());
                chk("rep_len", 32'(deadlock_trace_len), len_q.pop_front());
            end
        end
        dl_prev = deadlock;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {dl_detect_bcast, origin_vec, token_clear_vec, deadlock, deadlock_proc_id, deadlock_trace_len}, 0);
    endtask

    // One detection: request, origin, TRACE with noise on other bits, return at ret (0 = never), optional ack.
    task automatic trace(input logic [N-1:0] req, input int org, input int ret, input bit ack);
        logic [N-1:0] ob;
        ob = N'(1) << org;
        cyc();
        enable = 1'b1;
        proc_dl_vec = req;
        org_q.push_back(org);
        cyc();
        proc_dl_vec = '0;
        @(negedge clock);
        chk("org_bcast", 32'(dl_detect_bcast), 1);
        for (int c = 1; c <= TO; c++) begin
            cyc();
            proc_dl_vec = (c == ret) ? ob : (N'($urandom) & ~ob);
            @(negedge clock);
            chk("tr_bcast", 32'(dl_detect_bcast), 1);
            chk("tr_tc", 32'(token_clear_vec), (c == ret) ? 32'(ob) : 0);
            chk("tr_dl", 32'(deadlock), 0);
            if (c == ret) begin
                id_q.push_back(org);
                len_q.push_back(c);
                break;
            end
        end
        cyc();
        proc_dl_vec = '0;
        @(negedge clock);
        if (ret > 0) begin
            chk("rep_dl", 32'(deadlock), 1);
            chk("rep_bcast", 32'(dl_detect_bcast), 1);
            if (ack) begin
                cyc();
                report_ack = 1'b1;
                @(negedge clock);
                chk("rep_hold", 32'(deadlock), 1);
                cyc();
                report_ack = 1'b0;
                @(negedge clock);
                chk("ack_dl", 32'(deadlock), 0);
                chk("ack_bcast", 32'(dl_detect_bcast), 0);
            end
        end else begin
            chk("ab_bcast", 32'(dl_detect_bcast), 0);
            chk("ab_dl", 32'(deadlock), 0);
            chk("ab_org", 32'(origin_vec), 0);
            cyc();
        end
    endtask

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk_zero("rst_out");
        trace(4'b0100, 2, 3, 1'b1);
        // Fairness from a fresh pointer with every unit requesting.
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        trace(4'b1111, 0, 1, 1'b1);
        trace(4'b1111, 1, 2, 1'b1);
        trace(4'b1111, 2, 1, 1'b1);
        trace(4'b1111, 3, 4, 1'b1);
        trace(4'b1111, 0, 1, 1'b1);
        trace(4'b0010, 1, 0, 1'b1);
        trace(4'b1111, 2, TO, 1'b1);
        cyc();
        enable = 1'b0;
        proc_dl_vec = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("en_off_bcast", 32'(dl_detect_bcast), 0);
            chk("en_off_org", 32'(origin_vec), 0);
        end
        trace(4'b0011, 0, 2, 1'b1);
        trace(4'b0010, 1, 2, 1'b0);
        cyc();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clock);
        chk("async_pulse_dl", 32'(deadlock), 1);
        chk("async_pulse_id", 32'(deadlock_proc_id), 1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk_zero("rst_report");
        trace(4'b1111, 0, 1, 1'b1);
        cyc();
        proc_dl_vec = 4'b0100;
        org_q.push_back(2);
        cyc();
        proc_dl_vec = '0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk_zero("rst_trace");
        trace(4'b1111, 0, 1, 1'b1);
        cyc();
        chk("sb_org_empty", org_q.size(), 0);
        chk("sb_rep_empty", id_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/kernel_bc_hls_deadlock_report_ctrl.md
Name: kernel_bc_hls_deadlock_report_ctrl

Overview:
- Central sequencer for the per-process deadlock detect units of the kernel_bc dataflow region.
- Watches every unit's local deadlock flag and picks one process as the trace origin with round-robin arbitration.
- Broadcasts the global detect/freeze signal, waits for the report token to return to the origin, then clears it and publishes a sticky deadlock report.
- Aborts on timeout if the token never returns (false alarm).

Parameters:
PROC_NUM, 4, number of processes / detect units
PROC_ID_W, 2, width of process index; must satisfy 2**PROC_ID_W >= PROC_NUM
TIMEOUT, 64, maximum TRACE cycles before abort; must be >= 2
CNT_W, 8, width of trace length counter; 2**CNT_W > TIMEOUT

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  allows a new detection to start from IDLE
proc_dl_vec  in  PROC_NUM  per-unit local deadlock flag (unit dl_detect_out)
dl_detect_bcast  out  1  global detect/freeze, fanned out to every unit's dl_detect_in
origin_vec  out  PROC_NUM  one-hot origin strobe to the selected unit
token_clear_vec  out  PROC_NUM  one-hot token clear to the origin unit
deadlock  out  1  sticky deadlock confirmed flag
deadlock_proc_id  out  PROC_ID_W  index of the confirmed origin process
deadlock_trace_len  out  CNT_W  TRACE cycles until token return
report_ack  in  1  host acknowledge that releases REPORT

Behaviour:
- Reset: synchronous, active-high. On the next rising edge with reset=1: state=IDLE, rr_ptr=0, sel=0, cnt=0, and every output is 0.
- Reset mid-operation: the controller abandons the trace at once, with no completion or report.
- States: IDLE, ORIGIN, TRACE, REPORT, ABORT.
- IDLE:
  - Outputs are all 0.
  - If enable=1 and |proc_dl_vec=1, latch sel = first set bit at index >= rr_ptr, searching upward with wrap to 0. Then go to ORIGIN.
- ORIGIN (exactly 1 cycle):
  - origin_vec = 1<<sel and dl_detect_bcast = 1.
  - proc_dl_vec is ignored.
  - cnt <= 0. Go to TRACE.
- TRACE:
  - dl_detect_bcast = 1 and cnt increments each cycle.
  - If proc_dl_vec[sel]=1, the token has returned to the origin:
    - token_clear_vec = 1<<sel, combinationally in the same cycle (the unit samples token_clear in the cycle its dl_detect_out rises).
    - Latch deadlock_proc_id = sel and deadlock_trace_len = cnt+1, then go to REPORT.
  - Otherwise, if cnt = TIMEOUT-1, go to ABORT.
  - Bits of proc_dl_vec other than sel are ignored.
  - Return and timeout in the same cycle: return wins.
- REPORT:
  - deadlock = 1 and dl_detect_bcast = 1, so the network stays frozen.
  - The report outputs hold their values.
  - On report_ack=1: rr_ptr <= (sel+1) mod PROC_NUM, deadlock <= 0, go to IDLE.
  - report_ack outside REPORT is ignored.
- ABORT (1 cycle):
  - All outputs are 0.
  - rr_ptr <= (sel+1) mod PROC_NUM, go to IDLE.
- enable only gates the IDLE exit. Deasserting it mid-trace has no effect.
- Output registering:
  - origin_vec and dl_detect_bcast decode from the registered state.
  - token_clear_vec is the only output with a combinational input path (from proc_dl_vec).
- Invariants: origin_vec and token_clear_vec are each one-hot or zero. Both are never asserted in the same cycle.
- Latency:
  - A request seen in IDLE produces the origin strobe 1 cycle later.
  - The minimum request-to-deadlock time is 3 cycles (IDLE, ORIGIN, TRACE return, then deadlock=1).

Decomposition:
- Shared package kernel_bc_hls_dl_pkg holds:
  - the state enum (IDLE, ORIGIN, TRACE, REPORT, ABORT);
  - PROC_ID_W as a clog2 helper;
  - the default TIMEOUT.
- Sub-module kernel_bc_hls_rr_arbiter:
  - Inputs: PROC_NUM-wide request vector and the rr_ptr base.
  - Outputs: grant index and a valid bit.
  - Purely combinational, instantiated once.

Test Plan:
- PROC_NUM=4, rr_ptr=0, proc_dl_vec=4'b0100 held one cycle in IDLE, unit 2 returns 3 TRACE cycles later -> origin_vec=4'b0100 for 1 cycle, token_clear_vec=4'b0100 in the return cycle, deadlock=1, deadlock_proc_id=2, deadlock_trace_len=3; report_ack -> IDLE, rr_ptr=3.
- Fairness: proc_dl_vec=4'b1111 continuously with each trace acked -> successive origins 0,1,2,3,0.
- Timeout: TIMEOUT=8, origin 1 never returns -> ABORT after 8 TRACE cycles, deadlock stays 0, dl_detect_bcast drops, rr_ptr=2.
- Return on cycle cnt=TIMEOUT-1 -> REPORT (not ABORT), deadlock_trace_len=TIMEOUT.
- Noise: in TRACE with sel=0, proc_dl_vec=4'b0110 -> no transition and token_clear_vec=0. enable=0 with pending requests -> stays IDLE.
- reset=1 asserted in REPORT and in TRACE -> next edge: all outputs 0, state IDLE, rr_ptr=0. Asynchronous reset pulses between edges have no effect.
